seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
Reader side of the team's 7-segment display interface. It samples a time-multiplexed segment bus (segments plus one-hot digit select), debounces each digit dwell, and decodes each segment pattern back to a BCD code. It assembles one complete scan frame into a parallel BCD word for self-check and loopback of the display path. It sits between the display pins (or the display driver's outputs) and any checker or readback logic.

Parameters:
DIGITS, 4, number of multiplexed digits (one-hot select width)
STABLE_CYC, 4, consecutive identical samples needed to accept a digit (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
seg_in  in  7  segment lines a..g, active high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
dig_sel  in  DIGITS  digit enable, active high, expected one-hot
bcd_out  out  4*DIGITS  decoded frame; digit i at [4i+3:4i]
bcd_valid  out  1  one-cycle pulse when bcd_out is updated
err_invalid  out  1  qualified by bcd_valid: at least one digit in the frame had an invalid pattern
frame_err  out  1  one-cycle pulse when a frame is abandoned

Behaviour:
- Reset: bcd_out=0, bcd_valid=0, err_invalid=0, frame_err=0, FSM=IDLE, capture mask=0, stability counter=0. Reset mid-frame discards the partial frame, with no pulse.
- Input stage: seg_in and dig_sel are registered once. All logic uses the registered pair.
- Pattern table (segment hex to code): 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9.
- Any other pattern, including blank 00, decodes to code 4'hF and sets invalid.
- Stability:
  - The counter increments, saturating, while the registered pair equals the previous registered pair. It clears on any change.
  - A dwell is captured exactly once, when the pair has been identical for STABLE_CYC consecutive samples. A re-capture needs a change first.
  - If dig_sel is zero or not one-hot, the counter is held at 0 and no capture occurs.
- Latency: with the pair first present at input edge t and held, capture is written at edge t+STABLE_CYC.
- FSM states:
  - IDLE: ignore captures of digits other than 0. A capture of digit 0 stores its code, sets mask=1, and moves to COLLECT.
  - COLLECT, capture of digit i with mask[i]=0: store the code, set mask[i], OR invalid into the sticky frame error.
  - COLLECT, capture of digit i with mask[i]=1 before the mask is full:
    - If i==0, restart the frame (mask=1, sticky cleared, new code stored). No frame_err.
    - Otherwise, pulse frame_err and go to IDLE with mask=0.
  - When mask becomes all ones: on the next edge load bcd_out from the shadow, pulse bcd_valid, drive err_invalid from the sticky, and return to IDLE.
  - Last-digit dwell first present at edge t gives bcd_valid high at edge t+STABLE_CYC+1.
- bcd_out holds its value between frames. err_invalid holds until the next bcd_valid.
- A digit-0 capture in the same cycle that the frame completes is handled in IDLE semantics on the following capture only. Captures cannot occur on consecutive edges, because STABLE_CYC>=2.
- Widths: the counter is clog2(STABLE_CYC+1) bits. There is no arithmetic on data.

Decomposition:
- Shared package seg7_pkg holds:
  - segment constants SEG_0..SEG_9, in the encoder's bit order;
  - CODE_INVALID=4'hF;
  - FSM state encoding (IDLE, COLLECT).
- One combinational sub-module, seg7_pattern_decode: 7-bit pattern to 4-bit code plus an invalid flag. It is reusable by the checker.

Test Plan:
- DIGITS=4, STABLE_CYC=4. Dwell digits 0..3 for 8 cycles each, with patterns 7E, 30, 6D, 79 -> one bcd_valid pulse, bcd_out=16'h3210, err_invalid=0, frame_err=0.
- Same sequence with each dwell held for 3 cycles only -> no capture, no bcd_valid. Repeat with 4-cycle dwells -> bcd_valid, with timing exactly t+5 after the last dwell starts.
- Patterns 5B, 7F, 01, 70 on digits 0..3 -> bcd_out=16'h7F85, err_invalid=1. Next frame 7E, 30, 6D, 79 -> err_invalid=0.
- Digit order 0, 1, 3, 1 -> frame_err pulses once, no bcd_valid. Then a full 0..3 frame with 33 on every digit -> bcd_out=16'h4444.
- Digit order 0, 1, 0, 1, 2, 3 -> no frame_err, one bcd_valid carrying the second digit-0/1 values. dig_sel=4'b0011 held for 10 cycles -> no capture.
- Assert rst for 1 cycle after digits 0..2 are captured -> all outputs 0. A following full frame 7B, 5F, 30, 7E -> bcd_out=16'h0169.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path (encoder and reader).
package seg7_pkg;

    // Segment patterns, bit6=a .. bit0=g, active high.
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    localparam logic [3:0] CODE_INVALID = 4'hF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Multiplexed display bus plus the decoded frame returned by the reader.
interface seg7_scan_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                err_invalid;
    logic                frame_err;

    // master: whoever drives the display lines and consumes the frame
    modport master (
        output seg_in, dig_sel,
        input  bcd_out, bcd_valid, err_invalid, frame_err
    );

    // slave: the scan reader itself
    modport slave (
        input  seg_in, dig_sel,
        output bcd_out, bcd_valid, err_invalid, frame_err
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Segment pattern to BCD code; anything outside 0..9 is flagged invalid.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       invalid_o
);

    // Table lookup; blank and partial patterns fall to the default.
    always_comb begin
        code_o    = CODE_INVALID;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_0:   code_o = 4'd0;
            SEG_1:   code_o = 4'd1;
            SEG_2:   code_o = 4'd2;
            SEG_3:   code_o = 4'd3;
            SEG_4:   code_o = 4'd4;
            SEG_5:   code_o = 4'd5;
            SEG_6:   code_o = 4'd6;
            SEG_7:   code_o = 4'd7;
            SEG_8:   code_o = 4'd8;
            SEG_9:   code_o = 4'd9;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Samples the multiplexed display bus, debounces each digit dwell and
// assembles one full scan (digit 0 first) into a parallel BCD word.
//
// state   | meaning
// IDLE    | waiting for a stable digit-0 dwell to open a frame
// COLLECT | frame open; gathering remaining digits, emits when mask is full
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_reader_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYC + 1);

    logic [6:0]          seg_q, seg_prev_q;
    logic [DIGITS-1:0]   dig_q, dig_prev_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    state_e              state_q, state_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d, shadow_wr;
    logic                sticky_q, sticky_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                ferr_q, ferr_d;

    logic [3:0] code;
    logic       invalid;
    logic       onehot, same, capture, mask_full, hit;

    seg7_pattern_decode u_decode (
        .seg_i     (seg_q),
        .code_o    (code),
        .invalid_o (invalid)
    );

    // Register the raw bus once and keep the previous sample for comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            dig_q      <= '0;
            seg_prev_q <= '0;
            dig_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            seg_q      <= bus.seg_in;
            dig_q      <= bus.dig_sel;
            seg_prev_q <= seg_q;
            dig_prev_q <= dig_q;
            cnt_q      <= cnt_d;
        end
    end

    // Stability counter; capture fires once when the STABLE_CYC-th identical sample is held.
    always_comb begin
        onehot  = (dig_q != '0) && ((dig_q & (dig_q - DIGITS'(1))) == '0);
        same    = (seg_q == seg_prev_q) && (dig_q == dig_prev_q);
        cnt_d   = '0;
        if (onehot && same)
            cnt_d = (cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + CW'(1);
        capture   = onehot && same && (cnt_q == CW'(STABLE_CYC - 2));
        mask_full = &mask_q;
        hit       = |(mask_q & dig_q);
        shadow_wr = shadow_q;
        for (int i = 0; i < DIGITS; i++)
            if (dig_q[i]) shadow_wr[4*i +: 4] = code;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (capture && dig_q[0]) state_d = ST_COLLECT;
            ST_COLLECT:
                if (mask_full)                          state_d = ST_IDLE;
                else if (capture && hit && !dig_q[0])   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and frame bookkeeping; captures in the completion cycle are dropped.
    always_comb begin
        mask_d   = mask_q;
        shadow_d = shadow_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture && dig_q[0]) begin
                    mask_d   = DIGITS'(1);
                    sticky_d = invalid;
                    shadow_d = shadow_wr;
                end
            end
            ST_COLLECT: begin
                if (mask_full) begin
                    bcd_d   = shadow_q;
                    err_d   = sticky_q;
                    valid_d = 1'b1;
                    mask_d  = '0;
                end else if (capture) begin
                    if (!hit) begin
                        mask_d   = mask_q | dig_q;
                        sticky_d = sticky_q | invalid;
                        shadow_d = shadow_wr;
                    end else if (dig_q[0]) begin
                        mask_d   = DIGITS'(1);
                        sticky_d = invalid;
                        shadow_d = shadow_wr;
                    end else begin
                        mask_d = '0;
                        ferr_d = 1'b1;
                    end
                end
            end
            default: mask_d = '0;
        endcase
    end

    // Frame datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            shadow_q <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.bcd_valid   = valid_q;
    assign bus.err_invalid = err_q;
    assign bus.frame_err   = ferr_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (DIGITS=4, STABLE_CYC=4).
module tb_seg7_scan_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_reader_if #(.DIGITS(4)) bus ();

    seg7_scan_reader #(.DIGITS(4), .STABLE_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int valid_cyc = -1;
    int last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.bcd_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dwell(input int d, input logic [6:0] seg, input int n);
        logic [3:0] sel;
        sel = 4'b0001 << d;
        bus.seg_in  = seg;
        bus.dig_sel = sel;
        last_start  = cyc + 1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.seg_in  = 7'h00;
        bus.dig_sel = 4'b0000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3, input int n);
        dwell(0, p0, n);
        dwell(1, p1, n);
        dwell(2, p2, n);
        dwell(3, p3, n);
        idle(8);
    endtask

    task automatic clr_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        valid_cyc = -1;
    endtask

    initial begin
        bus.seg_in  = 7'h00;
        bus.dig_sel = 4'b0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_bcd_out", 32'(bus.bcd_out), 32'h0);
        chk("reset_valid", 32'(bus.bcd_valid), 32'h0);
        chk("reset_err", 32'(bus.err_invalid), 32'h0);
        chk("reset_ferr", 32'(bus.frame_err), 32'h0);
        @(posedge clk); #1;

        // basic frame, long dwells
        clr_counts();
        frame(7'h7E, 7'h30, 7'h6D, 7'h79, 8);
        chk("f1_valid_cnt", 32'(valid_cnt), 32'd1);
        chk("f1_bcd", 32'(bus.bcd_out), 32'h3210);
        chk("f1_err", 32'(bus.err_invalid), 32'h0);
        chk("f1_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // dwell one short of the threshold never captures
        clr_counts();
        bus.seg_in = 7'h00;
        frame(7'h30, 7'h6D, 7'h79, 7'h33, 3);
        chk("short_valid_cnt", 32'(valid_cnt), 32'd0);
        chk("short_bcd_hold", 32'(bus.bcd_out), 32'h3210);

        // exact-threshold dwells, check completion latency
        clr_counts();
        dwell(0, 7'h7F, 4);
        dwell(1, 7'h7B, 4);
        dwell(2, 7'h30, 4);
        dwell(3, 7'h5B, 4);
        chk("exact_last_start", 32'(last_start), 32'(last_start));
        idle(8);
        chk("exact_valid_cnt", 32'(valid_cnt), 32'd1);
        chk("exact_latency", 32'(valid_cyc), 32'(last_start + 5));
        chk("exact_bcd", 32'(bus.bcd_out), 32'h5198);

        // invalid pattern on digit 2
        clr_counts();
        frame(7'h5B, 7'h7F, 7'h01, 7'h70, 8);
        chk("inv_bcd", 32'(bus.bcd_out), 32'h7F85);
        chk("inv_err", 32'(bus.err_invalid), 32'h1);
        chk("inv_valid_cnt", 32'(valid_cnt), 32'd1);
        frame(7'h7E, 7'h30, 7'h6D, 7'h79, 8);
        chk("inv_clear_err", 32'(bus.err_invalid), 32'h0);
        chk("inv_clear_bcd", 32'(bus.bcd_out), 32'h3210);

        // repeated non-zero digit abandons the frame
        clr_counts();
        dwell(0, 7'h7E, 8);
        dwell(1, 7'h30, 8);
        dwell(3, 7'h79, 8);
        dwell(1, 7'h30, 8);
        idle(8);
        chk("abort_ferr_cnt", 32'(ferr_cnt), 32'd1);
        chk("abort_valid_cnt", 32'(valid_cnt), 32'd0);
        chk("abort_bcd_hold", 32'(bus.bcd_out), 32'h3210);
        clr_counts();
        frame(7'h33, 7'h33, 7'h33, 7'h33, 8);
        chk("after_abort_bcd", 32'(bus.bcd_out), 32'h4444);
        chk("after_abort_valid", 32'(valid_cnt), 32'd1);

        // repeated digit 0 restarts the frame silently
        clr_counts();
        dwell(0, 7'h7E, 8);
        dwell(1, 7'h30, 8);
        dwell(0, 7'h5B, 8);
        dwell(1, 7'h5F, 8);
        dwell(2, 7'h6D, 8);
        dwell(3, 7'h79, 8);
        idle(8);
        chk("restart_ferr_cnt", 32'(ferr_cnt), 32'd0);
        chk("restart_valid_cnt", 32'(valid_cnt), 32'd1);
        chk("restart_bcd", 32'(bus.bcd_out), 32'h3265);

        // non-one-hot select mid-frame must not capture (would restart on digit 0)
        clr_counts();
        dwell(0, 7'h7F, 8);
        dwell(1, 7'h7B, 8);
        bus.seg_in  = 7'h7E;
        bus.dig_sel = 4'b0011;
        repeat (10) @(posedge clk);
        #1;
        dwell(2, 7'h30, 8);
        dwell(3, 7'h33, 8);
        idle(8);
        chk("multi_sel_valid", 32'(valid_cnt), 32'd1);
        chk("multi_sel_ferr", 32'(ferr_cnt), 32'd0);
        chk("multi_sel_bcd", 32'(bus.bcd_out), 32'h4198);

        // reset mid-frame
        clr_counts();
        dwell(0, 7'h7E, 8);
        dwell(1, 7'h30, 8);
        dwell(2, 7'h6D, 8);
        bus.dig_sel = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_bcd", 32'(bus.bcd_out), 32'h0);
        chk("mid_rst_valid", 32'(bus.bcd_valid), 32'h0);
        chk("mid_rst_err", 32'(bus.err_invalid), 32'h0);
        chk("mid_rst_ferr", 32'(bus.frame_err), 32'h0);
        @(posedge clk); #1;
        dwell(3, 7'h79, 8);
        idle(8);
        chk("mid_rst_no_pulse", 32'(valid_cnt + ferr_cnt), 32'd0);
        frame(7'h7B, 7'h5F, 7'h30, 7'h7E, 8);
        chk("post_rst_bcd", 32'(bus.bcd_out), 32'h0169);
        chk("post_rst_valid", 32'(valid_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
